// File: rtl/calc_pkg.sv
// Shared key codes, FSM state type and key-decode helpers for the calculator entry block.
// KEY_PLUS..KEY_DIV double as the ALU operator codes.
package calc_pkg;

  localparam logic [3:0] KEY_PLUS = 4'd10;
  localparam logic [3:0] KEY_SUB  = 4'd11;
  localparam logic [3:0] KEY_MUL  = 4'd12;
  localparam logic [3:0] KEY_DIV  = 4'd13;
  localparam logic [3:0] KEY_EQ   = 4'd14;
  localparam logic [3:0] KEY_CLR  = 4'd15;

  typedef enum logic [1:0] {
    S_OP1,
    S_OPR,
    S_OP2,
    S_DONE
  } state_e;

  function automatic logic isDigit(input logic [3:0] key);
    return key <= 4'd9;
  endfunction

  function automatic logic isOperator(input logic [3:0] key);
    return (key >= KEY_PLUS) && (key <= KEY_DIV);
  endfunction

endpackage

// File: rtl/operand_accum.sv
// One decimal operand: binary value built as value*10+digit, with a digit count
// that saturates at Digits so extra keystrokes are dropped instead of overflowing.
module operand_accum #(
  parameter int Digits = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic                  accum_i,
  input  logic [3:0]            digit_i,
  output logic [Digits*4-1:0]   value_o,
  output logic                  hasDigit_o
);

  localparam int W  = Digits * 4;
  localparam int CW = $clog2(Digits + 1);

  logic [W-1:0]  value_q, value_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    value_d = value_q;
    count_d = count_q;
    if (clear_i) begin
      value_d = '0;
      count_d = '0;
    end else if (load_i) begin
      value_d = W'(digit_i);
      count_d = CW'(1);
    end else if (accum_i && (count_q < CW'(Digits))) begin
      // Below the digit limit the result is < 10^Digits, which always fits in 4*Digits bits.
      value_d = (value_q * W'(10)) + W'(digit_i);
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      count_q <= '0;
    end else begin
      value_q <= value_d;
      count_q <= count_d;
    end
  end

  assign value_o    = value_q;
  assign hasDigit_o = (count_q != '0);

endmodule

// File: rtl/calc_entry.sv
// Keypad entry front end: collects signed operand, operator, signed operand and
// pulses calc_valid once when '=' completes the expression.
module calc_entry
  import calc_pkg::*;
#(
  parameter int BCDdigits = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   key_valid,
  input  logic [3:0]             key_code,
  output logic                   key_ready,
  output logic [BCDdigits*4-1:0] operand1,
  output logic [BCDdigits*4-1:0] operand2,
  output logic                   op1_sign,
  output logic                   op2_sign,
  output logic [3:0]             operator,
  output logic                   calc_valid
);

  state_e     state_q, state_d;
  logic       op1Sign_q, op1Sign_d;
  logic       op2Sign_q, op2Sign_d;
  logic [3:0] operator_q, operator_d;
  logic       calcValid_q, calcValid_d;

  logic acc1Clear, acc1Load, acc1Accum, acc1HasDigit;
  logic acc2Clear, acc2Load, acc2Accum, acc2HasDigit;
  logic accept, keyDigit, keyOp;

  assign accept   = key_valid && key_ready;
  assign keyDigit = isDigit(key_code);
  assign keyOp    = isOperator(key_code);

  always_comb begin
    state_d     = state_q;
    op1Sign_d   = op1Sign_q;
    op2Sign_d   = op2Sign_q;
    operator_d  = operator_q;
    calcValid_d = 1'b0;
    acc1Clear   = 1'b0;
    acc1Load    = 1'b0;
    acc1Accum   = 1'b0;
    acc2Clear   = 1'b0;
    acc2Load    = 1'b0;
    acc2Accum   = 1'b0;
    if (accept) begin
      if (key_code == KEY_CLR) begin
        state_d    = S_OP1;
        op1Sign_d  = 1'b0;
        op2Sign_d  = 1'b0;
        operator_d = '0;
        acc1Clear  = 1'b0 | 1'b1;
        acc2Clear  = 1'b1;
      end else begin
        unique case (state_q)
          S_OP1: begin
            // A leading '-' is a sign; once digits exist it is the subtract operator.
            if (keyDigit) begin
              acc1Accum = 1'b1;
            end else if ((key_code == KEY_SUB) && !acc1HasDigit) begin
              op1Sign_d = 1'b1;
            end else if (keyOp && acc1HasDigit) begin
              operator_d = key_code;
              state_d    = S_OPR;
            end
          end
          S_OPR: begin
            if (keyDigit) begin
              acc2Load = 1'b1;
              state_d  = S_OP2;
            end else if ((key_code == KEY_SUB) && !op2Sign_q) begin
              op2Sign_d = 1'b1;
            end else if (keyOp && !op2Sign_q) begin
              operator_d = key_code;
            end
          end
          S_OP2: begin
            if (keyDigit) begin
              acc2Accum = 1'b1;
            end else if ((key_code == KEY_EQ) && acc2HasDigit) begin
              state_d     = S_DONE;
              calcValid_d = 1'b1;
            end
          end
          S_DONE: begin
            // A fresh digit after a result starts a brand-new expression.
            if (keyDigit) begin
              op1Sign_d  = 1'b0;
              op2Sign_d  = 1'b0;
              operator_d = '0;
              acc1Load   = 1'b1;
              acc2Clear  = 1'b1;
              state_d    = S_OP1;
            end
          end
          default: state_d = S_OP1;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_OP1;
      op1Sign_q   <= 1'b0;
      op2Sign_q   <= 1'b0;
      operator_q  <= '0;
      calcValid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op1Sign_q   <= op1Sign_d;
      op2Sign_q   <= op2Sign_d;
      operator_q  <= operator_d;
      calcValid_q <= calcValid_d;
    end
  end

  operand_accum #(.Digits(BCDdigits)) u_acc1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (acc1Clear),
    .load_i     (acc1Load),
    .accum_i    (acc1Accum),
    .digit_i    (key_code),
    .value_o    (operand1),
    .hasDigit_o (acc1HasDigit)
  );

  operand_accum #(.Digits(BCDdigits)) u_acc2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (acc2Clear),
    .load_i     (acc2Load),
    .accum_i    (acc2Accum),
    .digit_i    (key_code),
    .value_o    (operand2),
    .hasDigit_o (acc2HasDigit)
  );

  assign key_ready  = !calcValid_q;
  assign op1_sign   = op1Sign_q;
  assign op2_sign   = op2Sign_q;
  assign operator   = operator_q;
  assign calc_valid = calcValid_q;

endmodule
